// File: rtl/ova_capture_if.sv
// Camera-port capture bus: sensor-side inputs, packed-pixel outputs and FSM debug state.
// o_data_vld is a one-cycle strobe with no back-pressure; o_sof/o_eol are only meaningful while it is high.
interface ova_capture_if #(
    parameter int DATA_W = 16
);
    logic [7:0]        i_data;
    logic              href;
    logic              vsync;
    logic              i_fifo_empty;
    logic [DATA_W-1:0] o_data;
    logic              o_data_vld;
    logic              o_sof;
    logic              o_eol;
    logic              o_fifo_work_en;
    logic              o_line_err;
    logic [7:0]        o_drop_cnt;
    logic [1:0]        dbg_state;

    modport master (
        output i_data, href, vsync, i_fifo_empty,
        input  o_data, o_data_vld, o_sof, o_eol, o_fifo_work_en, o_line_err, o_drop_cnt, dbg_state
    );

    modport slave (
        input  i_data, href, vsync, i_fifo_empty,
        output o_data, o_data_vld, o_sof, o_eol, o_fifo_work_en, o_line_err, o_drop_cnt, dbg_state
    );
endinterface

// File: rtl/ova_capture.sv
// Camera-port pixel capture in the pclk domain: byte packing, line/frame position tracking,
// fixed-window crop with sof/eol markers, and frame-atomic admit/drop against the pixel FIFO.
module ova_capture #(
    parameter int BYTES_PER_PIX = 2,
    parameter bit VSYNC_POL     = 1'b1,
    parameter int X_START       = 0,
    parameter int X_SIZE        = 640,
    parameter int Y_START       = 0,
    parameter int Y_SIZE        = 480,
    parameter int CNT_W         = 12
) (
    input logic          i_pclk,
    input logic          rst,
    ova_capture_if.slave bus
);
    localparam int DATA_W = 8 * BYTES_PER_PIX;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0] BC_LAST = 2'(BYTES_PER_PIX - 1);

    typedef enum logic [1:0] {WAIT_VS, BLANK, CAPTURE, DROP} state_t;

    state_t state, state_next;

    logic              vs_act, vs_act_d, href_d;
    logic              vs_fall, href_rise, href_fall;
    logic              cap_ok, admit, drop;
    logic [1:0]        bc, bc_eff;
    logic [CNT_W-1:0]  x, x_eff, y;
    logic [DATA_W-1:0] pix, pix_next;
    logic              in_crop, sof_pend;

    logic [DATA_W-1:0] data_q;
    logic              vld_q, sof_q, eol_q, line_err_q;
    logic [7:0]        drop_cnt_q;

    assign vs_act    = (bus.vsync == VSYNC_POL);
    assign vs_fall   = vs_act_d && !vs_act;
    assign href_rise = bus.href && !href_d;
    assign href_fall = !bus.href && href_d;
    assign admit     = (state == BLANK) && vs_fall && bus.i_fifo_empty;
    assign drop      = (state == BLANK) && vs_fall && !bus.i_fifo_empty;
    // An active vsync wins over href, so a line in flight is abandoned the moment it asserts.
    assign cap_ok    = (state == CAPTURE) && !vs_act;

    always_ff @(posedge i_pclk or posedge rst) begin
        if (rst) state <= WAIT_VS;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_VS:       if (vs_act) state_next = BLANK;
            BLANK:         if (vs_fall) state_next = bus.i_fifo_empty ? CAPTURE : DROP;
            CAPTURE, DROP: if (vs_act) state_next = BLANK;
            default:       state_next = WAIT_VS;
        endcase
    end

    // Positions seen by the byte arriving on an href rise are those of a fresh line.
    always_comb begin
        bc_eff   = href_rise ? 2'd0 : bc;
        x_eff    = href_rise ? '0 : x;
        pix_next = (pix << 8) | DATA_W'(bus.i_data);
        in_crop  = (int'(x_eff) >= X_START) && (int'(x_eff) < X_START + X_SIZE) &&
                   (int'(y) >= Y_START) && (int'(y) < Y_START + Y_SIZE);
    end

    always_ff @(posedge i_pclk or posedge rst) begin
        if (rst) begin
            vs_act_d   <= 1'b0;
            href_d     <= 1'b0;
            bc         <= '0;
            x          <= '0;
            y          <= '0;
            pix        <= '0;
            sof_pend   <= 1'b0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            line_err_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            vs_act_d   <= vs_act;
            href_d     <= bus.href;
            vld_q      <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            line_err_q <= 1'b0;
            if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            if (admit) begin
                y        <= '0;
                x        <= '0;
                bc       <= '0;
                sof_pend <= 1'b1;
            end else if (cap_ok) begin
                if (bus.href) begin
                    pix <= pix_next;
                    if (bc_eff == BC_LAST) begin
                        bc <= '0;
                        x  <= (x_eff == CNT_MAX) ? x_eff : x_eff + 1'b1;
                        if (in_crop) begin
                            vld_q    <= 1'b1;
                            data_q   <= pix_next;
                            sof_q    <= sof_pend;
                            eol_q    <= (int'(x_eff) == X_START + X_SIZE - 1);
                            sof_pend <= 1'b0;
                        end
                    end else begin
                        bc <= bc_eff + 2'd1;
                        x  <= x_eff;
                    end
                end else if (href_fall) begin
                    bc         <= '0;
                    line_err_q <= (bc != 2'd0);
                    if (y != CNT_MAX) y <= y + 1'b1;
                end
            end else if (state == CAPTURE) begin
                bc <= '0;
            end
        end
    end

    assign bus.o_data         = data_q;
    assign bus.o_data_vld     = vld_q;
    assign bus.o_sof          = sof_q;
    assign bus.o_eol          = eol_q;
    assign bus.o_line_err     = line_err_q;
    assign bus.o_drop_cnt     = drop_cnt_q;
    assign bus.o_fifo_work_en = (state == CAPTURE);
    assign bus.dbg_state      = state;
endmodule

// File: tb/tb_ova_capture.sv
// Bench for ova_capture with a 2-byte pixel and a 3x2 crop window at (2,1):
// frame table plus hand-written vsync-mid-line, reset and drop-saturation sequences.
module tb_ova_capture;
    localparam int DW = 16;
    localparam int XS = 2, XN = 3, YS = 1, YN = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ova_capture_if #(.DATA_W(DW)) bus ();

    ova_capture #(
        .BYTES_PER_PIX(2), .VSYNC_POL(1'b1),
        .X_START(XS), .X_SIZE(XN), .Y_START(YS), .Y_SIZE(YN), .CNT_W(12)
    ) dut (
        .i_pclk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit empty;
        int lines;
        int nbytes;
        int exp_pix;
        int exp_sof;
        int exp_lerr;
        int exp_drop;
        bit exp_work;
    } frame_vec_t;

    frame_vec_t vecs[6];
    logic [17:0] exp_q[$];
    int n_cmp = 0, n_err = 0;
    int pix_seen = 0, sof_seen = 0, lerr_seen = 0;
    bit exp_sof_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, 32'(bus.o_data), 32'd0);
        check({tag, "_vld"}, 32'(bus.o_data_vld), 32'd0);
        check({tag, "_sof"}, 32'(bus.o_sof), 32'd0);
        check({tag, "_eol"}, 32'(bus.o_eol), 32'd0);
        check({tag, "_work_en"}, 32'(bus.o_fifo_work_en), 32'd0);
        check({tag, "_line_err"}, 32'(bus.o_line_err), 32'd0);
        check({tag, "_drop_cnt"}, 32'(bus.o_drop_cnt), 32'd0);
        check({tag, "_state"}, 32'(bus.dbg_state), 32'd0);
    endtask

    // Scoreboard: every strobed pixel must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_data_vld) begin
                pix_seen++;
                if (bus.o_sof) sof_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pixel: got data %0h sof %0b eol %0b, none expected",
                             bus.o_data, bus.o_sof, bus.o_eol);
                end else begin
                    check("pixel", 32'({bus.o_data, bus.o_sof, bus.o_eol}), 32'(exp_q.pop_front()));
                end
            end
            if (bus.o_line_err) lerr_seen++;
        end
    end

    task automatic start_frame(input bit empty);
        bus.href  = 1'b0;
        bus.vsync = 1'b1;
        repeat (3) tick();
        bus.i_fifo_empty = empty;
        bus.vsync        = 1'b0;
        tick();
        bus.i_fifo_empty = !empty;
        exp_sof_pend     = empty;
        pix_seen  = 0;
        sof_seen  = 0;
        lerr_seen = 0;
        repeat (2) tick();
    endtask

    // vs_at >= 0 raises vsync at that byte index while href is still high.
    task automatic drive_line(input int y, input int nbytes, input bit admit, input int vs_at);
        logic [7:0] prev, b;
        int x;
        prev = 8'h00;
        for (int k = 0; k < nbytes; k++) begin
            b = 8'($urandom_range(1, 255));
            if (vs_at >= 0 && k >= vs_at) bus.vsync = 1'b1;
            bus.i_data = b;
            bus.href   = 1'b1;
            if (admit && !(vs_at >= 0 && k >= vs_at) && (k % 2 == 1)) begin
                x = k / 2;
                if (x >= XS && x < XS + XN && y >= YS && y < YS + YN) begin
                    exp_q.push_back({prev, b, exp_sof_pend, (x == XS + XN - 1)});
                    exp_sof_pend = 1'b0;
                end
            end
            prev = b;
            tick();
        end
        bus.href = 1'b0;
        repeat (3) tick();
    endtask

    task automatic run_frame(input bit empty, input int lines, input int nbytes);
        start_frame(empty);
        for (int l = 0; l < lines; l++) drive_line(l, nbytes, empty, -1);
        repeat (2) tick();
    endtask

    initial begin
        vecs[0] = '{1'b1, 3, 16, 6, 1, 0, 0, 1'b1};
        vecs[1] = '{1'b0, 3, 16, 0, 0, 0, 1, 1'b0};
        vecs[2] = '{1'b1, 4, 16, 6, 1, 0, 1, 1'b1};
        vecs[3] = '{1'b1, 3, 7,  2, 1, 3, 1, 1'b1};
        vecs[4] = '{1'b1, 2, 10, 3, 1, 0, 1, 1'b1};
        vecs[5] = '{1'b0, 2, 9,  0, 0, 0, 2, 1'b0};

        rst = 1'b1;
        bus.i_data = 8'h00;
        bus.href = 1'b0;
        bus.vsync = 1'b0;
        bus.i_fifo_empty = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Data before the first vsync pulse must be ignored.
        drive_line(1, 16, 1'b0, -1);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].empty, vecs[i].lines, vecs[i].nbytes);
            check($sformatf("f%0d_pix", i), 32'(pix_seen), 32'(vecs[i].exp_pix));
            check($sformatf("f%0d_sof", i), 32'(sof_seen), 32'(vecs[i].exp_sof));
            check($sformatf("f%0d_line_err", i), 32'(lerr_seen), 32'(vecs[i].exp_lerr));
            check($sformatf("f%0d_drop_cnt", i), 32'(bus.o_drop_cnt), 32'(vecs[i].exp_drop));
            check($sformatf("f%0d_work_en", i), 32'(bus.o_fifo_work_en), 32'(vecs[i].exp_work));
        end

        // Vsync asserts mid-line: one pixel already out, the partial one is discarded.
        start_frame(1'b1);
        drive_line(0, 16, 1'b1, -1);
        drive_line(1, 12, 1'b1, 7);
        repeat (3) tick();
        check("vsmid_pix", 32'(pix_seen), 32'd1);
        check("vsmid_line_err", 32'(lerr_seen), 32'd0);
        check("vsmid_state", 32'(bus.dbg_state), 32'd1);
        check("vsmid_work_en", 32'(bus.o_fifo_work_en), 32'd0);
        run_frame(1'b1, 3, 16);
        check("vsmid_next_pix", 32'(pix_seen), 32'd6);
        check("vsmid_next_sof", 32'(sof_seen), 32'd1);

        // Reset mid-capture with a held nonzero pixel and a nonzero drop count.
        start_frame(1'b1);
        drive_line(0, 16, 1'b1, -1);
        drive_line(1, 6, 1'b1, -1);
        repeat (3) tick();
        check("pre_rst_drop_cnt", 32'(bus.o_drop_cnt), 32'd2);
        bus.href = 1'b1;
        bus.i_data = 8'h5A;
        tick();
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        tick();
        rst = 1'b0;
        bus.href = 1'b0;
        tick();
        for (int l = 0; l < 3; l++) drive_line(l, 16, 1'b0, -1);
        run_frame(1'b1, 3, 16);
        check("post_rst_pix", 32'(pix_seen), 32'd6);
        check("post_rst_sof", 32'(sof_seen), 32'd1);
        check("post_rst_drop_cnt", 32'(bus.o_drop_cnt), 32'd0);

        // Drop counter saturation.
        for (int i = 0; i < 300; i++) begin
            bus.vsync = 1'b1;
            repeat (2) tick();
            bus.i_fifo_empty = 1'b0;
            bus.vsync = 1'b0;
            repeat (2) tick();
            if (i == 99) check("drop_cnt_100", 32'(bus.o_drop_cnt), 32'd100);
        end
        check("drop_cnt_sat", 32'(bus.o_drop_cnt), 32'd255);
        check("drop_work_en", 32'(bus.o_fifo_work_en), 32'd0);

        repeat (5) tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
